// File: rtl/lsu_ctrl.sv
// Load/store unit for the MEMORY stage: one op at a time over a req/gnt/rvalid
// data bus, with lane steering, load extension, fault flags and a pc stall.
module lsu_ctrl #(
    parameter int  XLEN    = 32,
    parameter int  TIMEOUT = 255,
    localparam int BE_W    = XLEN / 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            ld_i,
    input  logic            st_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      rd_idx_i,
    input  logic            flush_i,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [BE_W-1:0] bus_be_o,
    output logic [XLEN-1:0] bus_wdata_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    input  logic            bus_err_i,
    output logic            rsp_valid_o,
    output logic            rsp_rd_wen_o,
    output logic [4:0]      rsp_rd_idx_o,
    output logic [XLEN-1:0] rsp_rd_wdata_o,
    output logic            ld_misalign_o,
    output logic            st_misalign_o,
    output logic            bus_err_o,
    output logic            stall_o
);
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Value of the counter in the last cycle allowed before giving up.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              ld_reg, we_reg, uns_reg, flushed_reg;
    logic              ld_mis_reg, st_mis_reg, err_reg;
    logic [1:0]        size_reg;
    logic [OFF_W-1:0]  off_reg;
    logic [4:0]        rd_idx_reg;
    logic [XLEN-1:0]   addr_reg, wdata_reg, rdata_reg;
    logic [BE_W-1:0]   be_reg;

    logic [OFF_W-1:0]  off;
    logic [3:0]        nbytes;
    logic              misalign, accept, timed_out;
    logic              capture_rsp, timeout_hit, flush_keep;
    logic [BE_W-1:0]   be_c;
    logic [XLEN-1:0]   wdata_sh, rdata_sh, rdata_ext;
    logic              show, fault;

    assign off       = addr_i[OFF_W-1:0];
    assign nbytes    = 4'd1 << size_i;
    assign accept    = (state_reg == S_IDLE) && req_valid_i && (ld_i || st_i) && !flush_i;
    assign timed_out = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);
    assign wdata_sh  = wdata_i << {off, 3'b000};
    assign rdata_sh  = bus_rdata_i >> {off_reg, 3'b000};

    // Alignment check on the incoming request; doubles never fit a 32-bit bus.
    always_comb begin
        misalign = 1'b0;
        case (size_i)
            2'd1:    misalign = addr_i[0];
            2'd2:    misalign = (addr_i[1:0] != 2'b00);
            2'd3:    misalign = (XLEN == 32) || (addr_i[2:0] != 3'b000);
            default: misalign = 1'b0;
        endcase
    end

    // One byte-lane enable per lane: lane lies inside [off, off+nbytes).
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_be
            assign be_c[gi] = (size_i == 2'd3) ||
                              ((gi >= int'(off)) && (gi < int'(off) + int'(nbytes)));
        end
    endgenerate

    // Load extension: fill with the sign (or zero) and overlay the low bytes.
    always_comb begin
        rdata_ext = rdata_sh;
        case (size_reg)
            2'd0: begin
                rdata_ext       = {XLEN{~uns_reg & rdata_sh[7]}};
                rdata_ext[7:0]  = rdata_sh[7:0];
            end
            2'd1: begin
                rdata_ext       = {XLEN{~uns_reg & rdata_sh[15]}};
                rdata_ext[15:0] = rdata_sh[15:0];
            end
            2'd2: begin
                rdata_ext       = {XLEN{~uns_reg & rdata_sh[31]}};
                rdata_ext[31:0] = rdata_sh[31:0];
            end
            default: rdata_ext = rdata_sh;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state and datapath events; a grant in the flush cycle wins over the abort.
    always_comb begin
        state_next  = state_reg;
        capture_rsp = 1'b0;
        timeout_hit = 1'b0;
        flush_keep  = 1'b0;
        case (state_reg)
            S_IDLE: if (accept) state_next = misalign ? S_RESP : S_REQ;
            S_REQ: begin
                if (bus_gnt_i) begin
                    state_next  = bus_rvalid_i ? S_RESP : S_WAIT;
                    capture_rsp = bus_rvalid_i;
                    flush_keep  = flush_i;
                end else if (flush_i) begin
                    state_next = S_IDLE;
                end else if (timed_out) begin
                    state_next  = S_RESP;
                    timeout_hit = 1'b1;
                end
            end
            S_WAIT: begin
                flush_keep = flush_i;
                if (bus_rvalid_i) begin
                    state_next  = S_RESP;
                    capture_rsp = 1'b1;
                end else if (timed_out) begin
                    state_next  = S_RESP;
                    timeout_hit = 1'b1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request latch, timeout counter and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg     <= '0;
            ld_reg      <= 1'b0;
            we_reg      <= 1'b0;
            uns_reg     <= 1'b0;
            flushed_reg <= 1'b0;
            ld_mis_reg  <= 1'b0;
            st_mis_reg  <= 1'b0;
            err_reg     <= 1'b0;
            size_reg    <= 2'd0;
            off_reg     <= '0;
            rd_idx_reg  <= 5'd0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            be_reg      <= '0;
        end else begin
            if (accept) begin
                cnt_reg     <= '0;
                ld_reg      <= ld_i;
                we_reg      <= st_i;
                uns_reg     <= unsigned_i;
                flushed_reg <= 1'b0;
                ld_mis_reg  <= ld_i & misalign;
                st_mis_reg  <= st_i & misalign;
                err_reg     <= 1'b0;
                size_reg    <= size_i;
                off_reg     <= off;
                rd_idx_reg  <= rd_idx_i;
                addr_reg    <= {addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                wdata_reg   <= wdata_sh;
                rdata_reg   <= '0;
                be_reg      <= be_c;
            end
            if (state_reg == S_REQ || state_reg == S_WAIT) cnt_reg <= cnt_reg + 1'b1;
            if (capture_rsp) begin
                err_reg   <= bus_err_i;
                rdata_reg <= rdata_ext;
            end
            if (timeout_hit) begin
                err_reg   <= 1'b1;
                rdata_reg <= '0;
            end
            if (flush_keep) flushed_reg <= 1'b1;
        end
    end

    // Bus side is driven only while requesting; response side only in RESP.
    assign bus_req_o      = (state_reg == S_REQ);
    assign bus_we_o       = bus_req_o & we_reg;
    assign bus_addr_o     = bus_req_o ? addr_reg  : '0;
    assign bus_be_o       = bus_req_o ? be_reg    : '0;
    assign bus_wdata_o    = bus_req_o ? wdata_reg : '0;
    assign req_ready_o    = (state_reg == S_IDLE);
    assign stall_o        = accept || (state_reg == S_REQ) || (state_reg == S_WAIT);
    assign show           = (state_reg == S_RESP) && !flushed_reg;
    assign fault          = ld_mis_reg | st_mis_reg | err_reg;
    assign rsp_valid_o    = show;
    assign rsp_rd_wen_o   = show & ld_reg & ~fault & (rd_idx_reg != 5'd0);
    assign rsp_rd_idx_o   = show ? rd_idx_reg : 5'd0;
    assign rsp_rd_wdata_o = (show & ld_reg & ~fault) ? rdata_reg : '0;
    assign ld_misalign_o  = show & ld_mis_reg;
    assign st_misalign_o  = show & st_mis_reg;
    assign bus_err_o      = show & err_reg;
endmodule
